// File: rtl/vend_pkg.sv
// Shared definitions for the vending controller: coin encodings, FSM states
// and coin/unit conversion helpers.
package vend_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;
  localparam logic [1:0] COIN_25   = 2'b11;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_VEND    = 2'd1,
    ST_PAYOUT  = 2'd2
  } state_t;

  function automatic logic [3:0] coin_units(input logic [1:0] c);
    case (c)
      COIN_5:  return 4'd1;
      COIN_10: return 4'd2;
      COIN_25: return 4'd5;
      default: return 4'd0;
    endcase
  endfunction

  // Largest single coin that does not exceed the given amount (in 5c units).
  function automatic logic [1:0] largest_coin(input logic [3:0] units);
    if (units >= 4'd5)      return COIN_25;
    else if (units >= 4'd2) return COIN_10;
    else if (units != 4'd0) return COIN_5;
    else                    return COIN_NONE;
  endfunction

endpackage

// File: rtl/vend_coin_sel.sv
// Maps remaining change to the next hopper coin and the units it removes.
module vend_coin_sel
  import vend_pkg::*;
(
  input  logic [3:0] change,
  output logic [1:0] coin,
  output logic [3:0] dec
);

  always_comb begin
    coin = largest_coin(change);
    dec  = coin_units(coin);
  end

endmodule

// File: rtl/vend_ctrl.sv
// Vending sale/change sequencer: credit accumulation, vend handshake and
// coin-by-coin hopper payout. Optional idle auto-refund via VEND_CTRL_TIMEOUT_EN.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned PRICE   = 6,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       r,
  input  logic [1:0] coin,
  input  logic       cancel,
  input  logic       vend_ack,
  input  logic       hopper_ack,
  output logic [3:0] credit,
  output logic       vend_req,
  output logic       hopper_req,
  output logic [1:0] hopper_coin,
  output logic       coin_rej,
  output logic       busy
);

  localparam logic [3:0] PRICE_U = 4'(PRICE);

  state_t     state, state_n;
  logic [3:0] change, change_n;
  logic [3:0] credit_n;
  logic [3:0] sum;
  logic [3:0] hopper_dec;
  logic [1:0] coin_n;
  logic [3:0] dec_n;
  logic       eff_cancel;

`ifdef VEND_CTRL_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  logic [TW-1:0] idle_cnt;
  logic          timeout_hit;

  assign timeout_hit = (state == ST_COLLECT) && (credit != '0) &&
                       (coin == COIN_NONE) && (idle_cnt == TW'(TIMEOUT));
  assign eff_cancel  = cancel | timeout_hit;

  always_ff @(posedge clk) begin
    if (r || state != ST_COLLECT || coin != COIN_NONE || credit == '0 || timeout_hit)
      idle_cnt <= '0;
    else
      idle_cnt <= idle_cnt + TW'(1);
  end
`else
  logic [31:0] timeout_unused;
  assign timeout_unused = TIMEOUT;
  assign eff_cancel     = cancel;
`endif

  assign sum = credit + coin_units(coin);

  always_comb begin
    state_n  = state;
    credit_n = credit;
    change_n = change;
    case (state)
      ST_COLLECT: begin
        // Coin is added before cancel is considered; a completed sale wins.
        if (coin != COIN_NONE) begin
          if (sum >= PRICE_U) begin
            change_n = sum - PRICE_U;
            credit_n = '0;
            state_n  = ST_VEND;
          end else if (eff_cancel) begin
            change_n = sum;
            credit_n = '0;
            state_n  = ST_PAYOUT;
          end else begin
            credit_n = sum;
          end
        end else if (eff_cancel && credit != '0) begin
          change_n = credit;
          credit_n = '0;
          state_n  = ST_PAYOUT;
        end
      end
      ST_VEND: begin
        if (vend_ack)
          state_n = (change != '0) ? ST_PAYOUT : ST_COLLECT;
      end
      ST_PAYOUT: begin
        if (hopper_ack) begin
          change_n = change - hopper_dec;
          if (change_n == '0)
            state_n = ST_COLLECT;
        end
      end
      default: state_n = ST_COLLECT;
    endcase
  end

  // Selection is made on the next-cycle change so hopper_coin is registered.
  vend_coin_sel u_coin_sel (
    .change (change_n),
    .coin   (coin_n),
    .dec    (dec_n)
  );

  always_ff @(posedge clk) begin
    if (r) begin
      state       <= ST_COLLECT;
      credit      <= '0;
      change      <= '0;
      hopper_dec  <= '0;
      vend_req    <= 1'b0;
      hopper_req  <= 1'b0;
      hopper_coin <= COIN_NONE;
      coin_rej    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      credit      <= credit_n;
      change      <= change_n;
      vend_req    <= (state_n == ST_VEND);
      hopper_req  <= (state_n == ST_PAYOUT);
      hopper_coin <= (state_n == ST_PAYOUT) ? coin_n : COIN_NONE;
      hopper_dec  <= (state_n == ST_PAYOUT) ? dec_n : '0;
      coin_rej    <= (coin != COIN_NONE) && (state != ST_COLLECT);
      busy        <= (state_n != ST_COLLECT);
    end
  end

endmodule

// File: tb/tb_vend_ctrl.sv
// Scoreboard bench for vend_ctrl (default build, PRICE 6).
module tb_vend_ctrl;
  import vend_pkg::*;

  localparam logic [1:0] EV_VEND = 2'd0;
  localparam logic [1:0] EV_HOP  = 2'd1;
  localparam logic [1:0] EV_REJ  = 2'd2;

  typedef struct packed {
    logic [1:0] kind;
    logic [1:0] val;
  } ev_t;

  logic       clk = 1'b0;
  logic       r = 1'b1;
  logic [1:0] coin = COIN_NONE;
  logic       cancel = 1'b0;
  logic       vend_ack = 1'b0;
  logic       hopper_ack = 1'b0;
  logic [3:0] credit;
  logic       vend_req, hopper_req, coin_rej, busy;
  logic [1:0] hopper_coin;

  int   checks = 0;
  int   failures = 0;
  ev_t  q[$];
  bit   done = 1'b0;
  bit   auto_ack = 1'b1;
  logic man_vend_ack = 1'b0;
  logic man_hop_ack = 1'b0;
  logic vend_req_q = 1'b0;

  vend_ctrl #(.PRICE(6), .TIMEOUT(255)) dut (
    .clk         (clk),
    .r           (r),
    .coin        (coin),
    .cancel      (cancel),
    .vend_ack    (vend_ack),
    .hopper_ack  (hopper_ack),
    .credit      (credit),
    .vend_req    (vend_req),
    .hopper_req  (hopper_req),
    .hopper_coin (hopper_coin),
    .coin_rej    (coin_rej),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_ev(input logic [1:0] kind, input logic [1:0] val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    q.push_back(e);
  endtask

  task automatic observe(input logic [1:0] kind, input logic [1:0] val);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      failures++;
      $display("FAIL event: got kind=%0d val=%0d expected none", kind, val);
    end else begin
      e = q.pop_front();
      if (e.kind !== kind || e.val !== val) begin
        failures++;
        $display("FAIL event: got kind=%0d val=%0d expected kind=%0d val=%0d",
                 kind, val, e.kind, e.val);
      end
    end
  endtask

  task automatic cyc(input logic [1:0] c, input logic x);
    coin   = c;
    cancel = x;
    @(posedge clk);
    #1;
    coin   = COIN_NONE;
    cancel = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 60; i++) begin
      if (!busy && q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    chk(name, {7'd0, (!busy && q.size() == 0)}, 8'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_credit"}, {4'd0, credit}, 8'd0);
    chk({tag, "_vend_req"}, {7'd0, vend_req}, 8'd0);
    chk({tag, "_hopper_req"}, {7'd0, hopper_req}, 8'd0);
    chk({tag, "_hopper_coin"}, {6'd0, hopper_coin}, 8'd0);
    chk({tag, "_coin_rej"}, {7'd0, coin_rej}, 8'd0);
    chk({tag, "_busy"}, {7'd0, busy}, 8'd0);
  endtask

  initial begin
    fork
      // Monitor and auto-responder: acks as soon as a request is seen.
      begin
        while (!done) begin
          @(negedge clk);
          vend_ack   = auto_ack ? vend_req : man_vend_ack;
          hopper_ack = auto_ack ? hopper_req : man_hop_ack;
          if (vend_req && !vend_req_q) observe(EV_VEND, 2'd0);
          if (hopper_req && hopper_ack) observe(EV_HOP, hopper_coin);
          if (coin_rej) observe(EV_REJ, 2'd0);
          vend_req_q = vend_req;
        end
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        r = 1'b0;
        @(posedge clk);
        #1;

        // 10c x3: exact price, no change
        cyc(COIN_10, 1'b0);
        chk("t1_credit2", {4'd0, credit}, 8'd2);
        cyc(COIN_10, 1'b0);
        chk("t1_credit4", {4'd0, credit}, 8'd4);
        expect_ev(EV_VEND, 2'd0);
        cyc(COIN_10, 1'b0);
        chk("t1_vend_req", {7'd0, vend_req}, 8'd1);
        chk("t1_credit0", {4'd0, credit}, 8'd0);
        wait_idle("t1_idle");
        chk("t1_credit_end", {4'd0, credit}, 8'd0);

        // 25c x2: change 4 units as 10c + 10c
        cyc(COIN_25, 1'b0);
        chk("t2_credit5", {4'd0, credit}, 8'd5);
        expect_ev(EV_VEND, 2'd0);
        expect_ev(EV_HOP, COIN_10);
        expect_ev(EV_HOP, COIN_10);
        cyc(COIN_25, 1'b0);
        wait_idle("t2_idle");

        // 5c, 10c, cancel: refund 10c then 5c
        cyc(COIN_5, 1'b0);
        chk("t3_credit1", {4'd0, credit}, 8'd1);
        cyc(COIN_10, 1'b0);
        chk("t3_credit3", {4'd0, credit}, 8'd3);
        expect_ev(EV_HOP, COIN_10);
        expect_ev(EV_HOP, COIN_5);
        cyc(COIN_NONE, 1'b1);
        chk("t3_vend_req", {7'd0, vend_req}, 8'd0);
        chk("t3_credit0", {4'd0, credit}, 8'd0);
        wait_idle("t3_idle");

        // 25c with cancel from zero credit, then a coin during payout
        expect_ev(EV_HOP, COIN_25);
        expect_ev(EV_REJ, 2'd0);
        cyc(COIN_25, 1'b1);
        chk("t4_hopper_coin", {6'd0, hopper_coin}, {6'd0, COIN_25});
        cyc(COIN_5, 1'b0);
        chk("t4_coin_rej", {7'd0, coin_rej}, 8'd1);
        chk("t4_credit0", {4'd0, credit}, 8'd0);
        @(posedge clk);
        #1;
        chk("t4_rej_pulse", {7'd0, coin_rej}, 8'd0);
        wait_idle("t4_idle");

        // Reset mid-payout, acks under manual control
        auto_ack = 1'b0;
        cyc(COIN_5, 1'b0);
        cyc(COIN_10, 1'b0);
        cyc(COIN_NONE, 1'b1);
        chk("t5_hopper_req", {7'd0, hopper_req}, 8'd1);
        chk("t5_hopper_coin", {6'd0, hopper_coin}, {6'd0, COIN_10});
        @(posedge clk);
        #1;
        chk("t5_hold_req", {7'd0, hopper_req}, 8'd1);
        r = 1'b1;
        @(posedge clk);
        #1;
        r = 1'b0;
        chk_reset_outputs("t5_rst");

        // Acks without a request are ignored
        man_vend_ack = 1'b1;
        man_hop_ack  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("t5_stray_busy", {7'd0, busy}, 8'd0);
        chk("t5_stray_vreq", {7'd0, vend_req}, 8'd0);
        man_vend_ack = 1'b0;
        man_hop_ack  = 1'b0;
        @(posedge clk);
        #1;
        cyc(COIN_25, 1'b0);
        chk("t5_credit5", {4'd0, credit}, 8'd5);
        auto_ack = 1'b1;
        expect_ev(EV_HOP, COIN_25);
        cyc(COIN_NONE, 1'b1);
        wait_idle("t5_idle");

        // 10c + 25c: change of 1 unit
        cyc(COIN_10, 1'b0);
        expect_ev(EV_VEND, 2'd0);
        expect_ev(EV_HOP, COIN_5);
        cyc(COIN_25, 1'b0);
        wait_idle("t6_idle");

        // Cancel with zero credit does nothing
        cyc(COIN_NONE, 1'b1);
        chk("t7_busy", {7'd0, busy}, 8'd0);
        chk("t7_hopper_req", {7'd0, hopper_req}, 8'd0);
        repeat (2) @(posedge clk);
        #1;
        done = 1'b1;
      end
    join
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL leftover: got %0d pending events expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
